mcmuldiv: RTL and testbench

Parametrised iterative multiply/divide unit that replaces the multi-cycle ALU's complex-op path. It executes the eight RV32M-style operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits between the execute reservation station and writeback, using the same issue/stall, writeback-stall and flush handshakes. Multiply retires `MUL_BITS` multiplier bits per cycle; divide is radix-2 restoring with early-out for special operands.

---
 rtl/mcmuldiv_if.sv | 36 +++
 rtl/mcmuldiv.sv | 156 +++++++++++++++
 tb/tb_mcmuldiv.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mcmuldiv_if.sv
// Issue / writeback / flush handshake between the reservation station,
// the iterative mul/div unit and writeback.
interface mcmuldiv_if #(
  parameter int XLEN    = 32,
  parameter int ROBID_W = 7,
  parameter int RD_W    = 6
);
  logic               exers_issue;
  logic [4:0]         exers_op;
  logic [ROBID_W-1:0] exers_robid;
  logic [RD_W-1:0]    exers_rd;
  logic [XLEN-1:0]    exers_op1;
  logic [XLEN-1:0]    exers_op2;
  logic               mcalu_stall;
  logic               mcalu_valid;
  logic               mcalu_error;
  logic [4:0]         mcalu_ecause;
  logic [ROBID_W-1:0] mcalu_robid;
  logic [RD_W-1:0]    mcalu_rd;
  logic [XLEN-1:0]    mcalu_result;
  logic               wb_mcalu_stall;
  logic               rob_flush;

  modport master (
    output exers_issue, exers_op, exers_robid, exers_rd, exers_op1, exers_op2,
           wb_mcalu_stall, rob_flush,
    input  mcalu_stall, mcalu_valid, mcalu_error, mcalu_ecause,
           mcalu_robid, mcalu_rd, mcalu_result
  );
  modport slave (
    input  exers_issue, exers_op, exers_robid, exers_rd, exers_op1, exers_op2,
           wb_mcalu_stall, rob_flush,
    output mcalu_stall, mcalu_valid, mcalu_error, mcalu_ecause,
           mcalu_robid, mcalu_rd, mcalu_result
  );
endinterface

// File: rtl/mcmuldiv.sv
// Iterative RV32M multiply/divide: MUL_BITS-per-cycle shift-add multiply,
// radix-2 restoring divide, special divides bypass straight to FIX.
module mcmuldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int ROBID_W  = 7,
  parameter int RD_W     = 6
) (
  input  logic     clk,
  input  logic     rst,
  mcmuldiv_if.slave bus
);
  localparam int K     = XLEN / MUL_BITS;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t               r_state, w_next, w_first;
  logic [2:0]           r_op;
  logic [ROBID_W-1:0]   r_robid;
  logic [RD_W-1:0]      r_rd;
  logic                 r_neg;
  logic [XLEN-1:0]      r_m;      // |multiplicand| or |divisor|
  logic [2*XLEN-1:0]    r_prod;   // product, or {remainder, quotient}
  logic [CNT_W-1:0]     r_cnt;
  logic [XLEN-1:0]      r_result;

  logic [2:0]           w_op;
  logic                 w_s1, w_s2, w_neg1, w_neg2, w_neg, w_div;
  logic                 w_div0, w_ovf, w_stall, w_accept;
  logic [XLEN-1:0]      w_abs1, w_abs2;
  logic [2*XLEN-1:0]    w_init;
  logic [XLEN-1:0]      w_minit;
  logic [XLEN+MUL_BITS-1:0] w_pp, w_hi_sum;
  logic [2*XLEN-1:0]    w_mul_nxt, w_div_nxt, w_pneg;
  logic [XLEN:0]        w_rsh;
  logic [XLEN+1:0]      w_sub;
  logic                 w_ge;
  logic [XLEN-1:0]      w_lo, w_hi, w_nlo, w_nhi, w_res;
  logic                 w_unused;

  assign w_unused = ^{bus.exers_op[4:3], w_sub[XLEN]};

  // Operand decode for the incoming issue
  always_comb begin
    w_op   = bus.exers_op[2:0];
    w_div  = w_op[2];
    w_s1   = w_div ? ~w_op[0] : (w_op[1:0] != 2'b11);
    w_s2   = w_div ? ~w_op[0] : ~w_op[1];
    w_neg1 = w_s1 & bus.exers_op1[XLEN-1];
    w_neg2 = w_s2 & bus.exers_op2[XLEN-1];
    w_abs1 = w_neg1 ? ('0 - bus.exers_op1) : bus.exers_op1;
    w_abs2 = w_neg2 ? ('0 - bus.exers_op2) : bus.exers_op2;
    w_div0 = w_div & (bus.exers_op2 == '0);
    w_ovf  = w_div & ~w_op[0] & (bus.exers_op1 == {1'b1, {(XLEN-1){1'b0}}})
             & (bus.exers_op2 == '1);
    w_neg  = (w_div & w_op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
    w_first = S_MUL;
    w_minit = w_abs1;
    w_init  = {{XLEN{1'b0}}, w_abs2};
    if (w_div) begin
      w_first = S_DIV;
      w_minit = w_abs2;
      w_init  = {{XLEN{1'b0}}, w_abs1};
      if (w_div0) begin
        w_first = S_FIX;
        w_init  = {bus.exers_op1, {XLEN{1'b1}}};
      end else if (w_ovf) begin
        w_first = S_FIX;
        w_init  = {{XLEN{1'b0}}, bus.exers_op1};
      end
    end
  end

  assign w_stall  = (r_state != S_IDLE) & ~((r_state == S_DONE) & ~bus.wb_mcalu_stall);
  assign w_accept = bus.exers_issue & ~w_stall & ~bus.rob_flush;

  // Datapath step functions
  assign w_pp      = {{MUL_BITS{1'b0}}, r_m} * {{XLEN{1'b0}}, r_prod[MUL_BITS-1:0]};
  assign w_hi_sum  = {{MUL_BITS{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_pp;
  assign w_mul_nxt = {w_hi_sum, r_prod[XLEN-1:MUL_BITS]};
  assign w_rsh     = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_sub     = {1'b0, w_rsh} - {2'b00, r_m};
  assign w_ge      = ~w_sub[XLEN+1];
  assign w_div_nxt = {(w_ge ? w_sub[XLEN-1:0] : w_rsh[XLEN-1:0]), r_prod[XLEN-2:0], w_ge};

  assign w_lo   = r_prod[XLEN-1:0];
  assign w_hi   = r_prod[2*XLEN-1:XLEN];
  assign w_nlo  = '0 - w_lo;
  assign w_nhi  = '0 - w_hi;
  assign w_pneg = '0 - r_prod;

  always_comb begin
    w_res = w_lo;
    case (r_op)
      3'b000:                 w_res = r_neg ? w_pneg[XLEN-1:0] : w_lo;
      3'b001, 3'b010, 3'b011: w_res = r_neg ? w_pneg[2*XLEN-1:XLEN] : w_hi;
      3'b100, 3'b101:         w_res = r_neg ? w_nlo : w_lo;
      default:                w_res = r_neg ? w_nhi : w_hi;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_first;
      S_MUL:  if (r_cnt == CNT_W'(K - 1)) w_next = S_FIX;
      S_DIV:  if (r_cnt == CNT_W'(XLEN - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (~bus.wb_mcalu_stall) w_next = w_accept ? w_first : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.rob_flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_robid  <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_m      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_robid <= bus.exers_robid;
      r_rd    <= bus.exers_rd;
      r_neg   <= w_neg & (w_first != S_FIX);
      r_m     <= w_minit;
      r_prod  <= w_init;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_MUL: begin r_prod <= w_mul_nxt; r_cnt <= r_cnt + 1'b1; end
        S_DIV: begin r_prod <= w_div_nxt; r_cnt <= r_cnt + 1'b1; end
        S_FIX: r_result <= w_res;
        default: ;
      endcase
    end
  end

  assign bus.mcalu_stall  = w_stall;
  assign bus.mcalu_valid  = (r_state == S_DONE);
  assign bus.mcalu_error  = 1'b0;
  assign bus.mcalu_ecause = '0;
  assign bus.mcalu_robid  = r_robid;
  assign bus.mcalu_rd     = r_rd;
  assign bus.mcalu_result = r_result;
endmodule

// File: tb/tb_mcmuldiv.sv
// Directed bench for mcmuldiv: latency, results, stall hold, flush, MUL_BITS variants.
module tb_mcmuldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcmuldiv_if #(.XLEN(32), .ROBID_W(7), .RD_W(6)) bus ();
  mcmuldiv_if #(.XLEN(32), .ROBID_W(7), .RD_W(6)) b1 ();
  mcmuldiv_if #(.XLEN(32), .ROBID_W(7), .RD_W(6)) b4 ();

  mcmuldiv #(.XLEN(32), .MUL_BITS(2), .ROBID_W(7), .RD_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  mcmuldiv #(.XLEN(32), .MUL_BITS(1), .ROBID_W(7), .RD_W(6)) u1  (.clk(clk), .rst(rst), .bus(b1));
  mcmuldiv #(.XLEN(32), .MUL_BITS(4), .ROBID_W(7), .RD_W(6)) u4  (.clk(clk), .rst(rst), .bus(b4));

  int checks = 0;
  int failures = 0;
  int seq = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic set_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] rid, input logic [5:0] rd);
    bus.exers_issue = 1'b1;
    bus.exers_op    = {2'b10, op};
    bus.exers_op1   = a;
    bus.exers_op2   = b;
    bus.exers_robid = rid;
    bus.exers_rd    = rd;
  endtask

  // Called just after a posedge; lat = cycles from accept cycle to first valid
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [6:0] rid, input logic [5:0] rd, output int lat);
    set_issue(op, a, b, rid, rd);
    @(posedge clk); #1;
    bus.exers_issue = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.mcalu_valid === 1'b1 || lat >= 200) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [6:0] rid;
    logic [5:0] rd;
    seq++;
    rid = 7'(seq * 13 + 3);
    rd  = 6'(seq * 5 + 1);
    run(op, a, b, rid, rd, lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, bus.mcalu_result, exp);
    chk({tag, " robid"}, {25'd0, bus.mcalu_robid}, {25'd0, rid});
    chk({tag, " rd"}, {26'd0, bus.mcalu_rd}, {26'd0, rd});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, l1, l4;
    logic [31:0] r1, r4;
    bus.exers_issue = 0; bus.exers_op = 0; bus.exers_robid = 0; bus.exers_rd = 0;
    bus.exers_op1 = 0; bus.exers_op2 = 0; bus.wb_mcalu_stall = 0; bus.rob_flush = 0;
    b1.exers_issue = 0; b1.exers_op = 0; b1.exers_robid = 0; b1.exers_rd = 0;
    b1.exers_op1 = 0; b1.exers_op2 = 0; b1.wb_mcalu_stall = 0; b1.rob_flush = 0;
    b4.exers_issue = 0; b4.exers_op = 0; b4.exers_robid = 0; b4.exers_rd = 0;
    b4.exers_op1 = 0; b4.exers_op2 = 0; b4.wb_mcalu_stall = 0; b4.rob_flush = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset valid", {31'd0, bus.mcalu_valid}, 32'd0);
    chk("reset stall", {31'd0, bus.mcalu_stall}, 32'd0);
    chk("reset result", bus.mcalu_result, 32'd0);
    chk("reset robid", {25'd0, bus.mcalu_robid}, 32'd0);
    chk("reset rd", {26'd0, bus.mcalu_rd}, 32'd0);
    @(posedge clk); #1;

    do_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 18);
    do_op("MULH",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 18);
    do_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 18);
    do_op("MULHU",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 18);
    do_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    do_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    do_op("DIVU",    3'b101, 32'd100,      32'd7,        32'd14,       34);
    do_op("DIVU/0",  3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 2);
    do_op("REMU/0",  3'b111, 32'd100,      32'd0,        32'd100,      2);
    do_op("REM/0",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2);
    do_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    do_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

    // Writeback stall held in DONE, then release with a back-to-back issue
    bus.wb_mcalu_stall = 1'b1;
    run(3'b101, 32'd100, 32'd7, 7'd21, 6'd4, lat);
    chk("stall latency", 32'(lat), 32'd34);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold valid", {31'd0, bus.mcalu_valid}, 32'd1);
      chk("hold stall", {31'd0, bus.mcalu_stall}, 32'd1);
      chk("hold result", bus.mcalu_result, 32'd14);
    end
    @(posedge clk); #1;
    bus.wb_mcalu_stall = 1'b0;
    set_issue(3'b000, 32'd3, 32'd5, 7'd99, 6'd33);
    #1;
    chk("release stall", {31'd0, bus.mcalu_stall}, 32'd0);
    chk("release valid", {31'd0, bus.mcalu_valid}, 32'd1);
    run(3'b000, 32'd3, 32'd5, 7'd99, 6'd33, lat);
    chk("b2b latency", 32'(lat), 32'd18);
    chk("b2b result", bus.mcalu_result, 32'd15);
    chk("b2b robid", {25'd0, bus.mcalu_robid}, 32'd99);
    @(posedge clk); #1;

    // Flush mid-divide
    set_issue(3'b101, 32'd1000, 32'd3, 7'd1, 6'd1);
    @(posedge clk); #1;
    bus.exers_issue = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.rob_flush = 1'b1;
    @(posedge clk); #1;
    bus.rob_flush = 1'b0;
    @(negedge clk);
    chk("flush div valid", {31'd0, bus.mcalu_valid}, 32'd0);
    chk("flush div stall", {31'd0, bus.mcalu_stall}, 32'd0);
    @(posedge clk); #1;
    do_op("REMU after flush", 3'b111, 32'd100, 32'd7, 32'd2, 34);

    // Flush in DONE under writeback stall; issue in the flush cycle dropped
    bus.wb_mcalu_stall = 1'b1;
    run(3'b000, 32'd6, 32'd7, 7'd5, 6'd5, lat);
    chk("pre-flush result", bus.mcalu_result, 32'd42);
    @(posedge clk); #1;
    bus.rob_flush = 1'b1;
    set_issue(3'b000, 32'd2, 32'd2, 7'd6, 6'd6);
    @(posedge clk); #1;
    bus.rob_flush = 1'b0; bus.exers_issue = 1'b0; bus.wb_mcalu_stall = 1'b0;
    @(negedge clk);
    chk("flush done valid", {31'd0, bus.mcalu_valid}, 32'd0);
    chk("flush done stall", {31'd0, bus.mcalu_stall}, 32'd0);

    // Issue in an IDLE flush cycle must not be accepted
    @(posedge clk); #1;
    bus.rob_flush = 1'b1;
    set_issue(3'b000, 32'd2, 32'd2, 7'd7, 6'd7);
    @(posedge clk); #1;
    bus.rob_flush = 1'b0; bus.exers_issue = 1'b0;
    @(negedge clk);
    chk("flush idle drop", {31'd0, bus.mcalu_stall}, 32'd0);
    @(posedge clk); #1;
    do_op("MULHU after flush", 3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, 18);

    // MUL latency for MUL_BITS = 1 and 4
    b1.exers_issue = 1'b1; b1.exers_op = 5'd0; b1.exers_op1 = 32'hFFFFFFFD; b1.exers_op2 = 32'd1000;
    b4.exers_issue = 1'b1; b4.exers_op = 5'd0; b4.exers_op1 = 32'hFFFFFFFD; b4.exers_op2 = 32'd1000;
    @(posedge clk); #1;
    b1.exers_issue = 1'b0; b4.exers_issue = 1'b0;
    lat = 1; l1 = 0; l4 = 0; r1 = '0; r4 = '0;
    while (lat < 100 && (l1 == 0 || l4 == 0)) begin
      @(negedge clk);
      if (l1 == 0 && b1.mcalu_valid === 1'b1) begin l1 = lat; r1 = b1.mcalu_result; end
      if (l4 == 0 && b4.mcalu_valid === 1'b1) begin l4 = lat; r4 = b4.mcalu_result; end
      @(posedge clk); #1;
      lat++;
    end
    chk("MUL_BITS=1 latency", 32'(l1), 32'd34);
    chk("MUL_BITS=1 result", r1, 32'hFFFFF448);
    chk("MUL_BITS=4 latency", 32'(l4), 32'd10);
    chk("MUL_BITS=4 result", r4, 32'hFFFFF448);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
